// File: rtl/serial_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a 16-bit MSB-first serializer.
// Each accepted word becomes one frame, followed by GAP idle bit-times.
module serial_tx_arbiter #(
  parameter int GAP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] din0,
  input  logic        req1,
  input  logic [15:0] din1,
  output logic        ack0,
  output logic        ack1,
  output logic        sd,
  output logic        frame,
  output logic        grant_id,
  output logic        done,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

  logic [1:0]  state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  gap_q, gap_d;
  logic        last_q, last_d;
  logic        grant_q, grant_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        frame_q, frame_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        win;

  // Handshake: reqN is a level held until the one-cycle ackN pulse; it is only
  // looked at while IDLE, and dinN is captured on that same accept edge.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    last_d  = last_q;
    grant_d = grant_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    win     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          // Contention goes to whoever was not served last.
          win     = (req0 & req1) ? ~last_q : req1;
          shreg_d = win ? din1 : din0;
          cnt_d   = 4'd0;
          state_d = S_SHIFT;
          last_d  = win;
          grant_d = win;
          ack0_d  = ~win;
          ack1_d  = win;
        end
      end
      S_SHIFT: begin
        shreg_d = {shreg_q[14:0], 1'b0};
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = 4'(GAP_M1);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) state_d = S_IDLE;
        else gap_d = gap_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
    frame_d = (state_d == S_SHIFT);
    done_d  = (state_d == S_SHIFT) && (cnt_d == 4'd15);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= 16'd0;
      cnt_q   <= 4'd0;
      gap_q   <= 4'd0;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // The register drains to zero over the frame, so bit 15 is already 0 in GAP/IDLE.
  assign sd       = shreg_q[15];
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign frame    = frame_q;
  assign grant_id = grant_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench: one instance with GAP=1 for most scenarios, one with GAP=0.
module tb_serial_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] din0, din1;
  logic        ack0, ack1, sd, frame, grant_id, done, busy;

  logic        z_req0, z_req1;
  logic [15:0] z_din0, z_din1;
  logic        z_ack0, z_ack1, z_sd, z_frame, z_grant_id, z_done, z_busy;

  int tests_run;
  int tests_failed;
  int cyc;
  int last_ack_cyc;
  int ack_gap;

  serial_tx_arbiter #(.GAP(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .din0(din0), .req1(req1), .din1(din1),
    .ack0(ack0), .ack1(ack1), .sd(sd), .frame(frame),
    .grant_id(grant_id), .done(done), .busy(busy)
  );

  serial_tx_arbiter #(.GAP(0)) dut_g0 (
    .clk(clk), .rst_n(rst_n),
    .req0(z_req0), .din0(z_din0), .req1(z_req1), .din1(z_din1),
    .ack0(z_ack0), .ack1(z_ack1), .sd(z_sd), .frame(z_frame),
    .grant_id(z_grant_id), .done(z_done), .busy(z_busy)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the accept, then collects the 16 serial bits of one frame on dut.
  task automatic capture_frame(input string tag, input logic exp_grant,
                               input logic [15:0] exp_word, input bit drop,
                               input bit scramble, input bit pulse1);
    logic [15:0] got;
    int frame_err, done_err, ack_err;
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (ack0 | ack1) seen = 1;
      else step();
    end
    check({tag, "_ack_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    check({tag, "_ack_pair"}, {30'd0, ack1, ack0}, exp_grant ? 32'd2 : 32'd1);
    check({tag, "_grant"}, 32'(grant_id), 32'(exp_grant));
    ack_gap = (last_ack_cyc >= 0) ? cyc - last_ack_cyc : -1;
    last_ack_cyc = cyc;
    if (drop) begin
      if (exp_grant) req1 = 1'b0;
      else req0 = 1'b0;
    end
    got = 16'd0;
    frame_err = 0;
    done_err = 0;
    ack_err = 0;
    for (int k = 0; k < 16; k++) begin
      got = {got[14:0], sd};
      if (!frame) frame_err++;
      if (done !== (k == 15)) done_err++;
      if (k > 0 && (ack0 | ack1)) ack_err++;
      if (grant_id !== exp_grant) ack_err++;
      if (scramble && k == 1) begin
        din0 = ~din0;
        din1 = ~din1;
      end
      if (pulse1 && k == 5) req1 = 1'b1;
      if (pulse1 && k == 6) req1 = 1'b0;
      step();
    end
    check({tag, "_word"}, 32'(got), 32'(exp_word));
    check({tag, "_frame_hi"}, 32'(frame_err), 32'd0);
    check({tag, "_done_last"}, 32'(done_err), 32'd0);
    check({tag, "_ack_once"}, 32'(ack_err), 32'd0);
  endtask

  initial begin
    int acks, lows, first, prev, bad_gap, run, max_run;
    bit seen;
    tests_run = 0;
    tests_failed = 0;
    last_ack_cyc = -1;
    ack_gap = -1;
    rst_n = 1'b0;
    req0 = 0; req1 = 0; din0 = 16'd0; din1 = 16'd0;
    z_req0 = 0; z_req1 = 0; z_din0 = 16'd0; z_din1 = 16'd0;

    // Reset state
    repeat (3) step();
    check("rst_outs", {25'd0, ack0, ack1, sd, frame, grant_id, done, busy}, 32'd0);
    check("rst_outs_g0", {25'd0, z_ack0, z_ack1, z_sd, z_frame, z_grant_id, z_done, z_busy}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single frame 16'hA5C3 from requester 0
    req0 = 1'b1;
    din0 = 16'hA5C3;
    capture_frame("single", 1'b0, 16'hA5C3, 1, 0, 0);
    check("single_gap_frame", {29'd0, frame, sd, busy}, 32'b001);
    step();
    check("single_idle_busy", 32'(busy), 32'd0);
    step();

    // Contention after a fresh reset: 0,1,0,1 every 18 cycles
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    req0 = 1'b1; req1 = 1'b1;
    din0 = 16'hFFFF; din1 = 16'h0001;
    last_ack_cyc = -1;
    for (int f = 0; f < 4; f++) begin
      capture_frame($sformatf("rr%0d", f), logic'(f % 2), (f % 2) ? 16'h0001 : 16'hFFFF, 0, 0, 0);
      if (f > 0) check($sformatf("rr%0d_period", f), 32'(ack_gap), 32'd18);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) step();

    // din1 altered one cycle after ack1 must not touch the frame
    req1 = 1'b1;
    din1 = 16'h8000;
    capture_frame("din_hold", 1'b1, 16'h8000, 1, 1, 0);
    repeat (3) step();

    // Short req1 pulse during SHIFT is ignored
    req0 = 1'b1;
    din0 = 16'h1234;
    capture_frame("pulse", 1'b0, 16'h1234, 1, 0, 1);
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      if (ack1 | frame) acks++;
      step();
    end
    check("pulse_no_ack1", 32'(acks), 32'd0);

    // Reset mid-frame at bit 7
    req0 = 1'b1;
    din0 = 16'hFFFF;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (ack0) seen = 1;
      else step();
    end
    check("abort_ack_seen", 32'(seen), 32'd1);
    req0 = 1'b0;
    repeat (7) step();
    check("abort_bit7_sd", 32'(sd), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_async", {29'd0, sd, frame, busy}, 32'd0);
    check("abort_done", 32'(done), 32'd0);
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done | sd | frame) acks++;
    end
    check("abort_quiet", 32'(acks), 32'd0);
    req0 = 1'b1; req1 = 1'b1;
    din1 = 16'h00F0;
    rst_n = 1'b1;
    last_ack_cyc = -1;
    capture_frame("post_rst", 1'b0, 16'hFFFF, 0, 0, 0);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) step();

    // GAP=0: back-to-back frames every 17 cycles with one low cycle between
    z_req1 = 1'b1;
    z_din1 = 16'h1357;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (z_ack1) seen = 1;
      else step();
    end
    check("g0_ack_seen", 32'(seen), 32'd1);
    acks = 0; lows = 0; first = cyc; prev = cyc; bad_gap = 0; run = 0; max_run = 0;
    for (int i = 0; i < 51; i++) begin
      if (z_ack1) begin
        if (acks > 0 && (cyc - prev) != 17) bad_gap++;
        prev = cyc;
        acks++;
      end
      if (!z_frame) begin
        lows++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      step();
    end
    z_req1 = 1'b0;
    check("g0_acks", 32'(acks), 32'd3);
    check("g0_period", 32'(bad_gap), 32'd0);
    check("g0_low_cycles", 32'(lows), 32'd3);
    check("g0_low_run", 32'(max_run), 32'd1);
    check("g0_span", 32'(prev - first), 32'd34);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_tx_arbiter.md
SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

Interface
REQ-001 Parameter GAP, default 1, sets the number of idle bit-times inserted after every frame; the legal range SHALL be 0..15.
REQ-002 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-004 req0  input  1  is the transmit request from requester 0, held high until ack0.
REQ-005 din0  input  16  is the word from requester 0.
REQ-006 req1  input  1  is the transmit request from requester 1, held high until ack1.
REQ-007 din1  input  16  is the word from requester 1.
REQ-008 ack0  output  1  SHALL be a one-cycle pulse indicating din0 was captured.
REQ-009 ack1  output  1  SHALL be a one-cycle pulse indicating din1 was captured.
REQ-010 sd  output  1  is the serial data, MSB first.
REQ-011 frame  output  1  SHALL be high during the 16 bit-times of a frame.
REQ-012 grant_id  output  1  is the owner of the current frame: 0 = requester 0, 1 = requester 1.
REQ-013 done  output  1  SHALL be high during the last bit-time of a frame.
REQ-014 busy  output  1  SHALL be high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and GAP; all outputs SHALL be registered.
REQ-016 Accept: at a rising edge with state IDLE and req0|req1 high, the block SHALL capture the granted din into the 16-bit shift register, clear the 4-bit bit counter to 0 and enter SHIFT.
REQ-017 In the cycle after the accept edge, the matching ack SHALL be 1 and frame SHALL be 1; sd SHALL equal din[15]; grant_id SHALL equal the winner.
REQ-018 In SHIFT, each edge SHALL shift the register left by one (LSB filled with 0) and increment the counter.
REQ-019 sd SHALL always equal shift-register bit 15, so bits 15..0 appear over 16 consecutive cycles.
REQ-020 done SHALL be 1 exactly in the cycle with counter = 15 and 0 otherwise.
REQ-021 At the edge with counter = 15, the FSM SHALL go to GAP if GAP > 0, otherwise to IDLE.
REQ-022 In GAP and IDLE, the outputs SHALL be frame = 0 and sd = 0.
REQ-023 GAP SHALL last exactly GAP cycles and then return to IDLE.
REQ-024 The minimum accept-to-accept period SHALL be 16 + GAP + 1 cycles.
REQ-025 Arbitration SHALL be round-robin:
- only one request high: that requester wins;
- both high: the requester not granted last wins.
REQ-026 The last-granted flag SHALL be updated only on accept.
REQ-027 Requests SHALL be sampled only in IDLE; req changes during SHIFT/GAP SHALL have no effect until the next IDLE.
REQ-028 din SHALL be sampled only at the accept edge; later din changes SHALL NOT alter the frame in flight.
REQ-029 A requester that drops req before being sampled in IDLE SHALL receive no ack and no frame.
REQ-030 grant_id SHALL hold its value from accept until the next accept.

Reset
REQ-031 While rst_n = 0, regardless of clk: state = IDLE, shift register = 0, counter = 0, last-granted = 1, ack0 = ack1 = sd = frame = done = busy = grant_id = 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately, with no done and no further sd bits.
REQ-033 After rst_n rises, the first accept with both req high SHALL grant requester 0.

Verification
REQ-034 Single frame, GAP = 1: req0 = 1, din0 = 16'hA5C3 -> ack0 pulses once; frame is high for 16 cycles; sd = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; done is high on the 16th; busy drops 2 cycles after done.
REQ-035 Contention: req0 = req1 = 1 held, din0 = 16'hFFFF, din1 = 16'h0001 -> frames alternate with grant_id = 0,1,0,1; accept-to-accept = 18 cycles.
REQ-036 GAP = 0: req1 continuously high -> frames start every 17 cycles; frame is low for exactly 1 cycle between frames.
REQ-037 din1 changed from 16'h8000 to 16'h7FFF one cycle after ack1 -> sd stream is still 1 followed by fifteen 0s.
REQ-038 rst_n pulled low at bit 7 of a frame of din0 = 16'hFFFF -> sd, frame and busy are 0 asynchronously; no done; with req0 = req1 = 1 after release, the next grant_id = 0.
REQ-039 req1 pulsed high for 1 cycle during SHIFT and low again before IDLE -> no ack1, no frame for requester 1.
